pipelined_adder_n: RTL

- Parametrised, pipelined successor to the team's fixed-width ripple adder: adds or subtracts two WIDTH-bit operands.
- Carry chain is split into STAGES registered segments for timing closure at larger widths.
- Valid/ready handshake with full backpressure; optional signed saturation.
- Sits between operand-producing datapath logic and the ALU result bus.

---
 rtl/pipelined_adder_n_if.sv | 28 ++
 rtl/pipelined_adder_n.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/pipelined_adder_n_if.sv
// Operand/result bus for pipelined_adder_n.
// Handshake: a beat moves on any rising clk edge where valid && ready are both 1.
// The producer holds valid and its payload stable until that edge; ready may change freely.
interface pipelined_adder_n_if #(
  parameter int WIDTH = 34
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, overflow
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, overflow
  );
endinterface

// File: rtl/pipelined_adder_n.sv
// Add/subtract of two WIDTH-bit operands with the carry chain cut into STAGES
// registered segments; elastic valid/ready pipeline with optional signed saturation.
module pipelined_adder_n #(
  parameter int WIDTH    = 34,
  parameter int STAGES   = 4,
  parameter bit SATURATE = 1'b0
) (
  input logic               clk,
  input logic               reset,
  pipelined_adder_n_if.slave bus
);
  localparam int CHUNK = (WIDTH + STAGES - 1) / STAGES;

  logic             valid_q [STAGES];
  logic             valid_d [STAGES];
  logic [WIDTH-1:0] a_q     [STAGES];
  logic [WIDTH-1:0] a_d     [STAGES];
  logic [WIDTH-1:0] b_q     [STAGES];
  logic [WIDTH-1:0] b_d     [STAGES];
  logic [WIDTH-1:0] s_q     [STAGES];
  logic [WIDTH-1:0] s_d     [STAGES];
  logic             c_q     [STAGES];
  logic             c_d     [STAGES];
  logic             ovf_q   [STAGES];
  logic             ovf_d   [STAGES];

  logic [STAGES-1:0] adv;
  logic              rdy;
  logic              src_v, src_c, src_ovf, seg_c, seg_ovf;
  logic [WIDTH-1:0]  src_a, src_b, src_s, seg_s;
  int                prev;

  // Ripples the carry through the bits owned by segment k; bits outside it pass through.
  function automatic void seg_add(
    input  int               k,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] s_i,
    input  logic             c_i,
    input  logic             ovf_i,
    output logic [WIDTH-1:0] s_o,
    output logic             c_o,
    output logic             ovf_o
  );
    logic c;
    logic c_next;
    s_o   = s_i;
    c     = c_i;
    ovf_o = ovf_i;
    for (int i = 0; i < WIDTH; i++) begin
      if (i >= k * CHUNK && i < (k + 1) * CHUNK) begin
        c_next = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
        s_o[i] = a_i[i] ^ b_i[i] ^ c;
        if (i == WIDTH - 1) ovf_o = c ^ c_next;
        c = c_next;
      end
    end
    c_o = c;
  endfunction

  always_comb begin
    adv     = '0;
    src_v   = 1'b0;
    src_a   = '0;
    src_b   = '0;
    src_s   = '0;
    src_c   = 1'b0;
    src_ovf = 1'b0;
    seg_s   = '0;
    seg_c   = 1'b0;
    seg_ovf = 1'b0;
    prev    = 0;
    // A stage may advance when it is empty or everything downstream of it can move.
    rdy = bus.out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      rdy    = !valid_q[k] || rdy;
      adv[k] = rdy;
    end
    for (int k = 0; k < STAGES; k++) begin
      valid_d[k] = valid_q[k];
      a_d[k]     = a_q[k];
      b_d[k]     = b_q[k];
      s_d[k]     = s_q[k];
      c_d[k]     = c_q[k];
      ovf_d[k]   = ovf_q[k];
      prev       = (k > 0) ? k - 1 : 0;
      if (k == 0) begin
        src_v   = bus.in_valid;
        src_a   = bus.a;
        src_b   = bus.sub ? ~bus.b : bus.b;
        src_s   = '0;
        src_c   = bus.sub ? 1'b1 : bus.cin;
        src_ovf = 1'b0;
      end else begin
        src_v   = valid_q[prev];
        src_a   = a_q[prev];
        src_b   = b_q[prev];
        src_s   = s_q[prev];
        src_c   = c_q[prev];
        src_ovf = ovf_q[prev];
      end
      seg_add(k, src_a, src_b, src_s, src_c, src_ovf, seg_s, seg_c, seg_ovf);
      if (SATURATE && k == STAGES - 1 && seg_ovf)
        seg_s = src_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      if (adv[k]) begin
        valid_d[k] = src_v;
        if (src_v) begin
          a_d[k]   = src_a;
          b_d[k]   = src_b;
          s_d[k]   = seg_s;
          c_d[k]   = seg_c;
          ovf_d[k] = seg_ovf;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < STAGES; k++) begin
      if (reset) begin
        valid_q[k] <= 1'b0;
        a_q[k]     <= '0;
        b_q[k]     <= '0;
        s_q[k]     <= '0;
        c_q[k]     <= 1'b0;
        ovf_q[k]   <= 1'b0;
      end else begin
        valid_q[k] <= valid_d[k];
        a_q[k]     <= a_d[k];
        b_q[k]     <= b_d[k];
        s_q[k]     <= s_d[k];
        c_q[k]     <= c_d[k];
        ovf_q[k]   <= ovf_d[k];
      end
    end
  end

  assign bus.in_ready  = adv[0];
  assign bus.out_valid = valid_q[STAGES-1];
  assign bus.sum       = s_q[STAGES-1];
  assign bus.cout      = c_q[STAGES-1];
  assign bus.overflow  = ovf_q[STAGES-1];
endmodule
